// File: rtl/meissa_pe_acc_if.sv
// Operand, config and result bundle for one MEISSA processing element.
// The master side drives operands and control; the slave side is the PE.
interface meissa_pe_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int CNT_WIDTH  = 8
);
    logic                  en;
    logic                  start;
    logic                  stop;
    logic                  cfg_signed;
    logic                  cfg_acc_en;
    logic [CNT_WIDTH-1:0]  cfg_acc_len;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] input_west;
    logic [DATA_WIDTH-1:0] input_north;
    logic [DATA_WIDTH-1:0] output_east;
    logic [DATA_WIDTH-1:0] output_south;
    logic                  valid_east;
    logic                  valid_south;
    logic [ACC_WIDTH-1:0]  cell_product;
    logic                  product_valid;
    logic                  busy;
    logic                  ovf;

    modport master (
        output en, start, stop, cfg_signed, cfg_acc_en, cfg_acc_len,
               in_valid, input_west, input_north,
        input  output_east, output_south, valid_east, valid_south,
               cell_product, product_valid, busy, ovf
    );

    modport slave (
        input  en, start, stop, cfg_signed, cfg_acc_en, cfg_acc_len,
               in_valid, input_west, input_north,
        output output_east, output_south, valid_east, valid_south,
               cell_product, product_valid, busy, ovf
    );
endinterface

// File: rtl/meissa_pe_acc.sv
// MEISSA processing element: forwards operands east/south and either emits
// each product (MULT) or sums a configurable number of products (ACC).
module meissa_pe_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int CNT_WIDTH  = 8
) (
    input logic                clk,
    input logic                rst,
    meissa_pe_acc_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

    state_t                state;
    logic                  sgn;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  count;
    logic [ACC_WIDTH-1:0]  acc;

    logic        [2*DATA_WIDTH-1:0] prod_u;
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]  p_ext;
    logic [ACC_WIDTH:0]    sum_c;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  add_ovf;
    logic [CNT_WIDTH-1:0]  len_eff;
    logic                  last;

    // Both products are formed at full width so the multiply never truncates.
    assign prod_u = {{DATA_WIDTH{1'b0}}, bus.input_west} * {{DATA_WIDTH{1'b0}}, bus.input_north};
    assign prod_s = $signed({{DATA_WIDTH{bus.input_west[DATA_WIDTH-1]}}, bus.input_west})
                  * $signed({{DATA_WIDTH{bus.input_north[DATA_WIDTH-1]}}, bus.input_north});
    assign p_ext  = sgn ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);

    assign sum_c   = {1'b0, acc} + {1'b0, p_ext};
    assign sum     = sum_c[ACC_WIDTH-1:0];
    assign add_ovf = sgn ? ((acc[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                            (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]))
                         : sum_c[ACC_WIDTH];

    assign len_eff = (len_q == '0) ? CNT_WIDTH'(1) : len_q;
    assign last    = (count == len_eff - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            sgn               <= 1'b0;
            len_q             <= '0;
            count             <= '0;
            acc               <= '0;
            bus.output_east   <= '0;
            bus.output_south  <= '0;
            bus.valid_east    <= 1'b0;
            bus.valid_south   <= 1'b0;
            bus.cell_product  <= '0;
            bus.product_valid <= 1'b0;
            bus.busy          <= 1'b0;
            bus.ovf           <= 1'b0;
        end else if (bus.en) begin
            bus.valid_east    <= bus.in_valid;
            bus.valid_south   <= bus.in_valid;
            if (bus.in_valid) begin
                bus.output_east  <= bus.input_west;
                bus.output_south <= bus.input_north;
            end
            bus.product_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sgn      <= bus.cfg_signed;
                        len_q    <= bus.cfg_acc_len;
                        bus.ovf  <= 1'b0;
                        acc      <= '0;
                        count    <= '0;
                        state    <= bus.cfg_acc_en ? ACC : MULT;
                        bus.busy <= 1'b1;
                    end
                end
                MULT: begin
                    if (bus.in_valid) begin
                        bus.cell_product  <= p_ext;
                        bus.product_valid <= 1'b1;
                    end
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ACC: begin
                    if (bus.in_valid && add_ovf) bus.ovf <= 1'b1;
                    if (bus.stop) begin
                        // Flush whatever partial group exists, including this beat.
                        if (bus.in_valid || count != '0) begin
                            bus.cell_product  <= bus.in_valid ? sum : acc;
                            bus.product_valid <= 1'b1;
                        end
                        acc      <= '0;
                        count    <= '0;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (bus.in_valid) begin
                        if (last) begin
                            bus.cell_product  <= sum;
                            bus.product_valid <= 1'b1;
                            acc               <= '0;
                            count             <= '0;
                        end else begin
                            acc   <= sum;
                            count <= count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_meissa_pe_acc.sv
// Directed bench for meissa_pe_acc: a default-width PE and a 16-bit-accumulator PE.
module tb_meissa_pe_acc;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    meissa_pe_acc_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) m ();
    meissa_pe_acc_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) s ();

    meissa_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(m.slave));
    meissa_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
        .clk(clk), .rst(rst), .bus(s.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        m.in_valid = 0; m.start = 0; m.stop = 0;
        s.in_valid = 0; s.start = 0; s.stop = 0;
    endtask

    task automatic beat(input logic [7:0] w, input logic [7:0] n);
        m.in_valid = 1; m.input_west = w; m.input_north = n;
        tick();
        m.in_valid = 0;
    endtask

    task automatic start_m(input logic sg, input logic acc_en, input logic [7:0] len);
        m.cfg_signed = sg; m.cfg_acc_en = acc_en; m.cfg_acc_len = len; m.start = 1;
        tick();
        m.start = 0;
    endtask

    task automatic test_reset();
        rst = 1; quiet();
        m.en = 1; s.en = 1;
        m.cfg_signed = 0; m.cfg_acc_en = 0; m.cfg_acc_len = 0;
        s.cfg_signed = 0; s.cfg_acc_en = 0; s.cfg_acc_len = 0;
        m.input_west = 0; m.input_north = 0; s.input_west = 0; s.input_north = 0;
        tick(); tick();
        rst = 0;
        checks++;
        if ({m.output_east, m.output_south, m.valid_east, m.valid_south, m.cell_product,
             m.product_valid, m.busy, m.ovf} !== '0) begin
            failures++;
            $display("FAIL reset_state: got east=%h south=%h cp=%h pv=%b busy=%b ovf=%b expected all 0",
                     m.output_east, m.output_south, m.cell_product, m.product_valid, m.busy, m.ovf);
        end
        // Reset in the middle of an ACC group with a beat present.
        start_m(0, 1, 4);
        beat(8'd5, 8'd5);
        beat(8'd6, 8'd6);
        rst = 1; m.in_valid = 1; m.input_west = 8'h33; m.input_north = 8'h44;
        tick();
        rst = 0; m.in_valid = 0;
        checks++;
        if ({m.output_east, m.output_south, m.valid_east, m.valid_south, m.cell_product,
             m.product_valid, m.busy, m.ovf} !== '0) begin
            failures++;
            $display("FAIL reset_mid_acc: got east=%h cp=%h pv=%b busy=%b expected all 0",
                     m.output_east, m.cell_product, m.product_valid, m.busy);
        end
    endtask

    task automatic test_mult();
        start_m(0, 0, 0);
        checks++;
        if (m.busy !== 1'b1) begin failures++; $display("FAIL mult_busy: got %b expected 1", m.busy); end
        beat(8'hFF, 8'h02);
        checks++;
        if (m.cell_product !== 24'd510 || m.product_valid !== 1'b1 || m.output_east !== 8'hFF ||
            m.valid_east !== 1'b1 || m.output_south !== 8'h02 || m.valid_south !== 1'b1) begin
            failures++;
            $display("FAIL mult_unsigned: got cp=%0d pv=%b east=%h ve=%b south=%h vs=%b expected 510 1 ff 1 02 1",
                     m.cell_product, m.product_valid, m.output_east, m.valid_east, m.output_south, m.valid_south);
        end
        // en=0 holds the pulse
        m.en = 0; tick(); m.en = 1;
        checks++;
        if (m.product_valid !== 1'b1 || m.cell_product !== 24'd510) begin
            failures++;
            $display("FAIL mult_en_hold: got pv=%b cp=%0d expected 1 510", m.product_valid, m.cell_product);
        end
        tick();
        checks++;
        if (m.product_valid !== 1'b0 || m.cell_product !== 24'd510 || m.valid_east !== 1'b0) begin
            failures++;
            $display("FAIL mult_idle_hold: got pv=%b cp=%0d ve=%b expected 0 510 0",
                     m.product_valid, m.cell_product, m.valid_east);
        end
        // stop with a beat in the same cycle still emits
        m.stop = 1; beat(8'd3, 8'd4); m.stop = 0;
        checks++;
        if (m.cell_product !== 24'd12 || m.product_valid !== 1'b1 || m.busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_stop_beat: got cp=%0d pv=%b busy=%b expected 12 1 0",
                     m.cell_product, m.product_valid, m.busy);
        end
        // IDLE beats forward only
        beat(8'd9, 8'd9);
        checks++;
        if (m.product_valid !== 1'b0 || m.cell_product !== 24'd12 || m.output_east !== 8'd9) begin
            failures++;
            $display("FAIL idle_forward: got pv=%b cp=%0d east=%0d expected 0 12 9",
                     m.product_valid, m.cell_product, m.output_east);
        end
    endtask

    task automatic test_signed();
        start_m(1, 0, 0);
        beat(8'hFF, 8'h02);
        checks++;
        if (m.cell_product !== 24'hFFFFFE || m.product_valid !== 1'b1) begin
            failures++;
            $display("FAIL signed_mult: got cp=%h pv=%b expected fffffe 1", m.cell_product, m.product_valid);
        end
        beat(8'h80, 8'h80);
        checks++;
        if (m.cell_product !== 24'h004000) begin
            failures++;
            $display("FAIL signed_min_sq: got cp=%h expected 004000", m.cell_product);
        end
        m.stop = 1; tick(); m.stop = 0;
        // signed ACC, len 2: -2 + 1 = -1
        start_m(1, 1, 2);
        beat(8'hFF, 8'h02);
        beat(8'h01, 8'h01);
        checks++;
        if (m.cell_product !== 24'hFFFFFF || m.product_valid !== 1'b1 || m.ovf !== 1'b0) begin
            failures++;
            $display("FAIL signed_acc: got cp=%h pv=%b ovf=%b expected ffffff 1 0",
                     m.cell_product, m.product_valid, m.ovf);
        end
        m.stop = 1; tick(); m.stop = 0;
    endtask

    task automatic test_acc_groups();
        int pulses;
        start_m(0, 1, 4);
        pulses = 0;
        beat(8'd1, 8'd2); pulses += m.product_valid;
        beat(8'd3, 8'd4); pulses += m.product_valid;
        tick();           pulses += m.product_valid;
        tick();           pulses += m.product_valid;
        beat(8'd5, 8'd6); pulses += m.product_valid;
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL acc_early_pulse: got %0d pulses expected 0", pulses); end
        beat(8'd7, 8'd8);
        checks++;
        if (m.cell_product !== 24'd100 || m.product_valid !== 1'b1 || m.busy !== 1'b1) begin
            failures++;
            $display("FAIL acc_group: got cp=%0d pv=%b busy=%b expected 100 1 1",
                     m.cell_product, m.product_valid, m.busy);
        end
        // back-to-back second group: 1+4+9+16
        beat(8'd1, 8'd1);
        checks++;
        if (m.product_valid !== 1'b0 || m.cell_product !== 24'd100) begin
            failures++;
            $display("FAIL acc_new_group: got pv=%b cp=%0d expected 0 100", m.product_valid, m.cell_product);
        end
        beat(8'd2, 8'd2);
        beat(8'd3, 8'd3);
        beat(8'd4, 8'd4);
        checks++;
        if (m.cell_product !== 24'd30 || m.product_valid !== 1'b1) begin
            failures++;
            $display("FAIL acc_group2: got cp=%0d pv=%b expected 30 1", m.cell_product, m.product_valid);
        end
        // stop with an empty group emits nothing
        m.stop = 1; tick(); m.stop = 0;
        checks++;
        if (m.product_valid !== 1'b0 || m.busy !== 1'b0 || m.cell_product !== 24'd30) begin
            failures++;
            $display("FAIL acc_stop_empty: got pv=%b busy=%b cp=%0d expected 0 0 30",
                     m.product_valid, m.busy, m.cell_product);
        end
        // len 0 behaves as len 1
        start_m(0, 1, 0);
        beat(8'd2, 8'd3);
        checks++;
        if (m.cell_product !== 24'd6 || m.product_valid !== 1'b1) begin
            failures++;
            $display("FAIL acc_len0: got cp=%0d pv=%b expected 6 1", m.cell_product, m.product_valid);
        end
        m.stop = 1; tick(); m.stop = 0;
    endtask

    task automatic test_stop_and_freeze();
        start_m(0, 1, 4);
        beat(8'd1, 8'd2);
        m.en = 0;
        m.in_valid = 1; m.input_west = 8'd9; m.input_north = 8'd9; m.stop = 1;
        tick(); tick(); tick();
        m.en = 1; m.in_valid = 0; m.stop = 0;
        checks++;
        if (m.output_east !== 8'd1 || m.output_south !== 8'd2 || m.valid_east !== 1'b1 ||
            m.product_valid !== 1'b0 || m.busy !== 1'b1 || m.cell_product !== 24'd6) begin
            failures++;
            $display("FAIL en_freeze: got east=%0d south=%0d ve=%b pv=%b busy=%b cp=%0d expected 1 2 1 0 1 6",
                     m.output_east, m.output_south, m.valid_east, m.product_valid, m.busy, m.cell_product);
        end
        m.stop = 1; beat(8'd3, 8'd4); m.stop = 0;
        checks++;
        if (m.cell_product !== 24'd14 || m.product_valid !== 1'b1 || m.busy !== 1'b0) begin
            failures++;
            $display("FAIL acc_stop_flush: got cp=%0d pv=%b busy=%b expected 14 1 0",
                     m.cell_product, m.product_valid, m.busy);
        end
    endtask

    task automatic test_overflow();
        s.cfg_signed = 0; s.cfg_acc_en = 1; s.cfg_acc_len = 2; s.start = 1;
        tick(); s.start = 0;
        s.in_valid = 1; s.input_west = 8'd255; s.input_north = 8'd255;
        tick();
        checks++;
        if (s.ovf !== 1'b0 || s.product_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first: got ovf=%b pv=%b expected 0 0", s.ovf, s.product_valid);
        end
        tick();
        s.in_valid = 0;
        checks++;
        if (s.cell_product !== 16'd64514 || s.ovf !== 1'b1 || s.product_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_wrap: got cp=%0d ovf=%b pv=%b expected 64514 1 1",
                     s.cell_product, s.ovf, s.product_valid);
        end
        s.stop = 1; tick(); s.stop = 0;
        checks++;
        if (s.ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", s.ovf); end
        s.start = 1; tick(); s.start = 0;
        checks++;
        if (s.ovf !== 1'b0 || s.busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: got ovf=%b busy=%b expected 0 1", s.ovf, s.busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_signed();
        test_acc_groups();
        test_stop_and_freeze();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
